dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory port between two requesters: the CPU load/store
//  path (port cpu_*) and the debug/program-loader path (port dbg_*).
//  Sits between the ALU-address/store-data outputs and data_memory.
//  Sequences each access through a fixed-wait FSM.
//  Stalls the single-cycle core via cpu_stall while its access is pending or blocked.
// PARAMETERS
//  AW           32  address width (byte address)
//  DW           32  data width
//  WAIT_CYCLES  1   extra cycles mem_en is held beyond the first; range 0..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  cpu_req    in   1   CPU access request; held high until cpu_ack
//  cpu_we     in   1   1=store, 0=load
//  cpu_addr   in   AW  byte address
//  cpu_wdata  in   DW  store data
//  cpu_be     in   4   byte enables
//  cpu_rdata  out  DW  load data; valid while cpu_ack=1
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational)
//  dbg_req    in   1   debug request; same rules as cpu_req
//  dbg_we     in   1   1=write, 0=read
//  dbg_addr   in   AW  byte address
//  dbg_wdata  in   DW  write data
//  dbg_be     in   4   byte enables
//  dbg_rdata  out  DW  read data; valid while dbg_ack=1
//  dbg_ack    out  1   one-cycle completion pulse
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable; only high while mem_en=1
//  mem_addr   out  AW  registered address
//  mem_wdata  out  DW  registered write data
//  mem_be     out  4   registered byte enables
//  mem_rdata  in   DW  memory read data; valid in the last ACCESS cycle
// BEHAVIOUR
//  Reset values
//   - All outputs are 0 on rst, except cpu_stall, which follows cpu_req.
//   - FSM=IDLE, cnt=0, last_grant=DBG.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE
//   - Arbitrate among the asserted requests.
//   - On a grant: latch we/addr/wdata/be of the winner, record gnt, load cnt=WAIT_CYCLES,
//     go to ACCESS. With no request, stay in IDLE.
//  ACCESS
//   - mem_en=1; mem_we = latched we.
//   - cnt!=0: decrement cnt, stay in ACCESS.
//   - cnt==0: register mem_rdata (loads only; otherwise hold the old value), go to DONE.
//  DONE
//   - Pulse ack for gnt for exactly one cycle, with rdata valid; mem_en=0.
//   - Go to IDLE. No arbitration occurs in DONE.
//  Latency
//   - Request sampled in IDLE at cycle 0; mem_en high for cycles 1..WAIT_CYCLES+1.
//   - ack high in cycle WAIT_CYCLES+2.
//   - Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
//  Simultaneous requests: resolved by the arbitration policy (see CONFIGURATION).
//  Held inputs
//   - Request inputs are latched at grant.
//   - Changes to addr/wdata after the grant have no effect on the current access.
//  req dropped before ack
//   - The access still completes, and ack still pulses; this is a protocol
//     violation that is tolerated.
//  Lower-priority request arriving during another access: waits, is arbitrated in
//   the next IDLE cycle.
//  rst mid-operation: asynchronous return to IDLE; mem_en/mem_we deassert at once.
//   An in-flight write may or may not have committed; no ack is issued.
//  cpu_rdata/dbg_rdata are separate registers; the non-granted one holds its value.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined
//   - Round-robin: on a tie, grant the port not in last_grant.
//   - last_grant updates at every grant.
//  DMEM_ARB_RR_EN undefined
//   - Fixed priority: CPU always wins a tie; last_grant is unused.
//   - Debug can starve under continuous CPU traffic.
// TESTING (WAIT_CYCLES=1)
//  1. CPU load addr 0x10, mem returns 0xDEADBEEF
//     -> mem_en in cycles 1-2; cpu_ack=1 with cpu_rdata=0xDEADBEEF in cycle 3;
//        cpu_stall=1 in cycles 0-2.
//  2. CPU store 0x20 <- 0x12345678, be=4'b0011
//     -> mem_we=1, mem_be=4'b0011, mem_addr=0x20 in cycles 1-2; cpu_ack in cycle 3;
//        dbg_ack stays 0.
//  3. cpu_req and dbg_req raised together, two accesses each
//     -> fixed priority: order CPU,CPU,DBG,DBG;
//        RR_EN (last_grant=DBG after reset): order CPU,DBG,CPU,DBG.
//  4. dbg_req held; cpu_req raised in ACCESS of the debug access
//     -> debug completes first; CPU granted in the next IDLE; cpu_stall=1 throughout.
//  5. rst asserted in the 2nd ACCESS cycle of a store
//     -> mem_en=0 immediately, no ack; after release, a new request completes normally.
//  6. cpu_addr changed on the cycle after the grant
//     -> mem_addr keeps the original address; ack timing is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the CPU load/store path (cpu_*)
// and the debug/program-loader path (dbg_*). Each access runs through a
// fixed-wait FSM: IDLE -> ACCESS -> DONE -> IDLE. The single-cycle core is held
// through cpu_stall_o while its request is outstanding.
//
// Timing, with the request sampled in IDLE at cycle 0:
//   mem_en_o high in cycles 1 .. WAIT_CYCLES+1
//   ack high in cycle WAIT_CYCLES+2, with rdata valid
//   back-to-back throughput is one access per WAIT_CYCLES+3 cycles
//
// Handshake: a requester raises *_req_i with its we/addr/wdata/be and holds it
// until it sees the one-cycle *_ack_o pulse. The command fields are copied at
// grant, so later changes to them do not affect the access in flight. If a
// request is dropped early, the access still completes and ack still pulses.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin on a tie (the port not granted last wins)
//   undefined : fixed priority, CPU wins every tie (debug can starve)
//
// Parameters:
//   AW          address width (byte address)
//   DW          data width
//   WAIT_CYCLES extra mem_en cycles beyond the first, 0..15
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i/be_i   CPU command
//   cpu_rdata_o, cpu_ack_o        CPU load data and completion pulse
//   cpu_stall_o                   cpu_req_i & ~cpu_ack_o (combinational)
//   dbg_req_i/we_i/addr_i/wdata_i/be_i   debug command
//   dbg_rdata_o, dbg_ack_o        debug read data and completion pulse
//   mem_en_o, mem_we_o            memory strobe and write enable
//   mem_addr_o/wdata_o/be_o       registered command to memory
//   mem_rdata_i                   memory read data, valid in last ACCESS cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    input  logic [3:0]    cpu_be_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic          cpu_stall_o,

    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    input  logic [3:0]    dbg_be_i,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          dbg_ack_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          gnt_q;       // owner of the access in flight
    logic          gnt_d;       // winner of arbitration this cycle
    logic          req_any;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          cpu_ack_q;
    logic          dbg_ack_q;

`ifdef DMEM_ARB_RR_EN
    logic          last_grant_q;
`endif

    // Arbitration, only consumed in IDLE.
    always_comb begin
        req_any = cpu_req_i | dbg_req_i;
        gnt_d   = GNT_CPU;
        if (cpu_req_i && dbg_req_i) begin
`ifdef DMEM_ARB_RR_EN
            gnt_d = ~last_grant_q;
`else
            gnt_d = GNT_CPU;
`endif
        end else if (dbg_req_i) begin
            gnt_d = GNT_DBG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            gnt_q       <= GNT_CPU;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'd0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= GNT_DBG;
`endif
        end else begin
            // Acks are single-cycle pulses.
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        gnt_q    <= gnt_d;
                        cnt_q    <= 4'(WAIT_CYCLES);
                        mem_en_q <= 1'b1;
                        state_q  <= ST_ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_grant_q <= gnt_d;
`endif
                        if (gnt_d == GNT_CPU) begin
                            mem_we_q    <= cpu_we_i;
                            mem_addr_q  <= cpu_addr_i;
                            mem_wdata_q <= cpu_wdata_i;
                            mem_be_q    <= cpu_be_i;
                        end else begin
                            mem_we_q    <= dbg_we_i;
                            mem_addr_q  <= dbg_addr_i;
                            mem_wdata_q <= dbg_wdata_i;
                            mem_be_q    <= dbg_be_i;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Last ACCESS cycle: memory data is valid now. Stores
                        // leave the requester's read register untouched.
                        if (!mem_we_q) begin
                            if (gnt_q == GNT_CPU) cpu_rdata_q <= mem_rdata_i;
                            else                  dbg_rdata_q <= mem_rdata_i;
                        end
                        if (gnt_q == GNT_CPU) cpu_ack_q <= 1'b1;
                        else                  dbg_ack_q <= 1'b1;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with WAIT_CYCLES=1. Cycle 0 of each scenario
// is the IDLE cycle in which the request is first presented; outputs are
// sampled 1ns (or 2ns after a same-cycle input change) past the rising edge.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_be;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [3:0]    dbg_be;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  int total;
  int bad;

  // grant order scoreboard: 0 = CPU, 1 = DBG
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  dmem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_be_i(cpu_be), .cpu_rdata_o(cpu_rdata),
    .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_be_i(dbg_be), .dbg_rdata_o(dbg_rdata),
    .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cmd(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  task automatic dbg_cmd(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
    mem_rdata = '0;
    tick(); tick();
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be, cpu_ack, dbg_ack,
         cpu_rdata, dbg_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%0b we=%0b addr=%h wd=%h be=%h ack=%0b/%0b rd=%h/%h want all 0",
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata);
    end
    cpu_req = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b1) begin
      bad++; $display("FAIL reset_stall_follows_req: got %0b want 1", cpu_stall);
    end
    cpu_req = 1'b0;
    #1;
    total++;
    if (cpu_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall_idle: got %0b want 0", cpu_stall);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_load();
    mem_rdata = 32'hDEADBEEF;
    cpu_cmd(1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    for (int c = 0; c <= 4; c++) begin
      total++;
      if (mem_en !== (c == 1 || c == 2)) begin
        bad++; $display("FAIL load_mem_en c%0d: got %0b want %0b", c, mem_en, (c == 1 || c == 2));
      end
      total++;
      if (cpu_ack !== (c == 3)) begin
        bad++; $display("FAIL load_ack c%0d: got %0b want %0b", c, cpu_ack, (c == 3));
      end
      total++;
      if (cpu_stall !== (c <= 2)) begin
        bad++; $display("FAIL load_stall c%0d: got %0b want %0b", c, cpu_stall, (c <= 2));
      end
      if (c == 1) begin
        total++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          bad++; $display("FAIL load_cmd: addr=%h we=%0b want addr=00000010 we=0", mem_addr, mem_we);
        end
      end
      if (c == 3) begin
        total++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_cpu_store();
    mem_rdata = 32'hBAD0BAD0;
    cpu_cmd(1'b1, 32'h20, 32'h12345678, 4'b0011);
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 1 || c == 2) begin
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
            mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
          bad++;
          $display("FAIL store_cmd c%0d: en=%0b we=%0b be=%b addr=%h wd=%h want 1 1 0011 00000020 12345678",
                   c, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
      end else begin
        total++;
        if (mem_we !== 1'b0) begin
          bad++; $display("FAIL store_we_outside c%0d: got %0b want 0", c, mem_we);
        end
      end
      total++;
      if (cpu_ack !== (c == 3)) begin
        bad++; $display("FAIL store_ack c%0d: got %0b want %0b", c, cpu_ack, (c == 3));
      end
      total++;
      if (dbg_ack !== 1'b0) begin
        bad++; $display("FAIL store_dbg_ack c%0d: got %0b want 0", c, dbg_ack);
      end
      if (c == 3) begin
        total++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL store_rdata_hold: got %h want deadbeef", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_arbitration();
    int cpu_left;
    int dbg_left;
    int last_c;
    // reset so the tie-breaker starts from its post-reset state
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_q.delete(); got_q.delete();
`ifdef DMEM_ARB_RR_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
    mem_rdata = 32'h11112222;
    cpu_cmd(1'b0, 32'h100, 32'h0, 4'hF);
    dbg_cmd(1'b0, 32'h200, 32'h0, 4'hF);
    cpu_left = 2; dbg_left = 2; last_c = -1;
    for (int c = 0; c < 40 && (cpu_left > 0 || dbg_left > 0); c++) begin
      if (cpu_ack === 1'b1) begin
        got_q.push_back(1'b0); cpu_left--; last_c = c;
        if (cpu_left == 0) cpu_req = 1'b0;
      end
      if (dbg_ack === 1'b1) begin
        got_q.push_back(1'b1); dbg_left--; last_c = c;
        if (dbg_left == 0) dbg_req = 1'b0;
      end
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    total++;
    if (cpu_left != 0 || dbg_left != 0) begin
      bad++; $display("FAIL arb_timeout: left cpu=%0d dbg=%0d want 0 0", cpu_left, dbg_left);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL arb_count: got %0d grants want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL arb_order[%0d]: got %0d want %0d (0=cpu 1=dbg)", i, got_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (last_c != 15) begin
      bad++; $display("FAIL arb_throughput: last ack cycle %0d want 15", last_c);
    end
    total++;
    if (dbg_rdata !== 32'h11112222) begin
      bad++; $display("FAIL arb_dbg_rdata: got %h want 11112222", dbg_rdata);
    end
    tick();
  endtask

  task automatic test_late_cpu();
    mem_rdata = 32'h0BADF00D;
    dbg_cmd(1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 1) begin
        cpu_cmd(1'b0, 32'h44, 32'h0, 4'hF);
        #1;
      end
      total++;
      if (dbg_ack !== (c == 3)) begin
        bad++; $display("FAIL late_dbg_ack c%0d: got %0b want %0b", c, dbg_ack, (c == 3));
      end
      total++;
      if (cpu_ack !== (c == 7)) begin
        bad++; $display("FAIL late_cpu_ack c%0d: got %0b want %0b", c, cpu_ack, (c == 7));
      end
      if (c >= 1 && c <= 7) begin
        total++;
        if (cpu_stall !== (c < 7)) begin
          bad++; $display("FAIL late_stall c%0d: got %0b want %0b", c, cpu_stall, (c < 7));
        end
      end
      if (c == 2) begin
        total++;
        if (mem_addr !== 32'h40) begin
          bad++; $display("FAIL late_dbg_addr: got %h want 00000040", mem_addr);
        end
      end
      if (c == 3) begin
        total++;
        if (dbg_rdata !== 32'h0BADF00D) begin
          bad++; $display("FAIL late_dbg_rdata: got %h want 0badf00d", dbg_rdata);
        end
        dbg_req = 1'b0;
      end
      if (c == 5) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h44) begin
          bad++; $display("FAIL late_cpu_cmd: en=%0b addr=%h want 1 00000044", mem_en, mem_addr);
        end
      end
      if (c == 7) cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_store();
    cpu_cmd(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
    tick();                       // cycle 1, first ACCESS
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      bad++; $display("FAIL rst_pre: en=%0b we=%0b want 1 1", mem_en, mem_we);
    end
    tick();                       // cycle 2, second ACCESS
    rst = 1'b1;
    #1;
    total++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rst_immediate: en=%0b we=%0b want 0 0", mem_en, mem_we);
    end
    cpu_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0 || mem_en !== 1'b0) begin
        bad++; $display("FAIL rst_no_ack c%0d: ack=%0b/%0b en=%0b want 0", c, cpu_ack, dbg_ack, mem_en);
      end
    end
    rst = 1'b0;
    tick();
    mem_rdata = 32'hCAFEF00D;
    cpu_cmd(1'b0, 32'h34, 32'h0, 4'hF);
    #1;
    for (int c = 0; c <= 4; c++) begin
      total++;
      if (cpu_ack !== (c == 3)) begin
        bad++; $display("FAIL rst_recover_ack c%0d: got %0b want %0b", c, cpu_ack, (c == 3));
      end
      if (c == 3) begin
        total++;
        if (cpu_rdata !== 32'hCAFEF00D) begin
          bad++; $display("FAIL rst_recover_rdata: got %h want cafef00d", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_addr_change();
    mem_rdata = 32'h55667788;
    cpu_cmd(1'b0, 32'h50, 32'h0, 4'hF);
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 1) begin
        cpu_addr = 32'h99;
        #1;
      end
      if (c == 1 || c == 2) begin
        total++;
        if (mem_addr !== 32'h50) begin
          bad++; $display("FAIL addr_hold c%0d: got %h want 00000050", c, mem_addr);
        end
      end
      total++;
      if (cpu_ack !== (c == 3)) begin
        bad++; $display("FAIL addr_ack c%0d: got %0b want %0b", c, cpu_ack, (c == 3));
      end
      if (c == 3) begin
        total++;
        if (cpu_rdata !== 32'h55667788) begin
          bad++; $display("FAIL addr_rdata: got %h want 55667788", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_arbitration();
    test_late_cpu();
    test_reset_mid_store();
    test_addr_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
